// File: rtl/lc3_pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage LC-3 core: stage load enables,
// stage valid bits, branch redirect (with deferral behind a pending fetch) and a stall counter.
module lc3_pipe_ctrl #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  input  logic                 load_use,
  input  logic                 br_taken,
  input  logic [WIDTH-1:0]     br_target,
  output logic                 load_pc,
  output logic                 pc_redirect,
  output logic [WIDTH-1:0]     pc_target,
  output logic                 load_if_id,
  output logic                 load_id_ex,
  output logic                 load_ex_mem,
  output logic                 load_mem_wb,
  output logic                 valid_if_id,
  output logic                 valid_id_ex,
  output logic                 valid_ex_mem,
  output logic                 valid_mem_wb,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic {RUN, REDIRECT} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] redirect_q, redirect_d;
  logic             dstall, br, lu;
  logic             nv_if_id, nv_id_ex, nv_ex_mem, nv_mem_wb;

  // Hazard inputs only count when the stage that raised them holds a real instruction.
  assign dstall = valid_ex_mem & dmem_req & ~dmem_resp;
  assign br     = valid_ex_mem & br_taken;
  assign lu     = load_use & valid_if_id & valid_id_ex;

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = (state == REDIRECT) ? redirect_q : br_target;
    nv_if_id    = 1'b0;
    nv_id_ex    = valid_if_id;
    nv_ex_mem   = valid_id_ex;
    nv_mem_wb   = valid_ex_mem;
    state_d     = state;
    redirect_d  = redirect_q;

    // A D-memory stall freezes everything, including a branch waiting in EX/MEM.
    if (!reset && !dstall) begin
      if (state == REDIRECT) begin
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        if (imem_resp) begin
          load_pc     = 1'b1;
          pc_redirect = 1'b1;
          state_d     = RUN;
        end
      end else if (br) begin
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        nv_id_ex    = 1'b0;
        nv_ex_mem   = 1'b0;
        if (imem_resp) begin
          load_pc     = 1'b1;
          pc_redirect = 1'b1;
        end else begin
          state_d    = REDIRECT;
          redirect_d = br_target;
        end
      end else if (lu) begin
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        nv_id_ex    = 1'b0;
      end else if (!imem_resp) begin
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
      end else begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        nv_if_id    = 1'b1;
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      redirect_q   <= '0;
      valid_if_id  <= 1'b0;
      valid_id_ex  <= 1'b0;
      valid_ex_mem <= 1'b0;
      valid_mem_wb <= 1'b0;
      stall_count  <= '0;
    end else begin
      state      <= state_d;
      redirect_q <= redirect_d;
      if (load_if_id)  valid_if_id  <= nv_if_id;
      if (load_id_ex)  valid_id_ex  <= nv_id_ex;
      if (load_ex_mem) valid_ex_mem <= nv_ex_mem;
      if (load_mem_wb) valid_mem_wb <= nv_mem_wb;
      if (!load_pc && stall_count != '1) stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end

endmodule
